// File: rtl/mem_wr_burst_feeder.sv
// Write-side front end for the DDR burst controller: stream FIFO plus fixed-size write-burst issuer.
// Optional statistics counters are compiled in when MEM_WR_STATS_EN is defined.
module mem_wr_burst_feeder #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 24,
  parameter int FIFO_AW       = 8,
  parameter int BURST_LEN     = 128
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic [ADDR_BITS-1:0]     base_addr,
  input  logic [ADDR_BITS-1:0]     frame_words,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MEM_DATA_BITS-1:0] in_data,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     frame_done,
  output logic [FIFO_AW:0]         fifo_level,
  output logic [15:0]              burst_cnt,
  output logic [15:0]              stall_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW0   = (ADDR_BITS > FIFO_AW + 1) ? ADDR_BITS : FIFO_AW + 1;
  localparam int CW    = (CW0 > 11) ? CW0 : 11;

  localparam logic [CW-1:0]      BURST_LEN_C = CW'(BURST_LEN);
  localparam logic [FIFO_AW:0]   DEPTH_C     = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  logic [MEM_DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]       r_wptr;
  logic [FIFO_AW-1:0]       r_rptr;
  logic [FIFO_AW:0]         r_level;
  logic [MEM_DATA_BITS-1:0] r_rd_data;

  state_t                   r_state;
  logic                     r_req;
  logic [9:0]               r_len;
  logic [ADDR_BITS-1:0]     r_addr;
  logic [ADDR_BITS-1:0]     r_offset;
  logic [9:0]               r_pops_done;
  logic                     r_frame_done;

  logic                     w_in_ready;
  logic                     w_push;
  logic                     w_pop;
  logic [CW-1:0]            w_remaining;
  logic [CW-1:0]            w_level_c;
  logic [CW-1:0]            w_nominal;
  logic [CW-1:0]            w_len_c;
  logic                     w_avail;
  logic                     w_end_of_frame;

  // in_ready is held low during reset so every output reads 0 while rst is asserted
  assign w_in_ready = !rst && (r_level < DEPTH_C);
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = (r_state == ST_BURST) && wr_burst_data_req && (r_pops_done < r_len);

  assign w_remaining    = CW'(frame_words) - CW'(r_offset);
  assign w_level_c      = CW'(r_level);
  assign w_nominal      = (BURST_LEN_C < w_remaining) ? BURST_LEN_C : w_remaining;
  assign w_len_c        = (w_level_c < w_nominal) ? w_level_c : w_nominal;
  assign w_avail        = (w_level_c >= w_nominal) || (flush && (r_level != '0));
  assign w_end_of_frame = (CW'(r_offset) + CW'(r_len)) == CW'(frame_words);

  always_ff @(posedge mem_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + FIFO_AW'(1);
        r_rd_data <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW + 1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Burst FSM: IDLE waits for enough data (or flush), BURST holds req until finish
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_len        <= '0;
      r_addr       <= '0;
      r_offset     <= '0;
      r_pops_done  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_avail) begin
            r_state     <= ST_BURST;
            r_req       <= 1'b1;
            r_len       <= 10'(w_len_c);
            r_addr      <= base_addr + r_offset;
            r_pops_done <= '0;
          end
        end
        ST_BURST: begin
          if (w_pop) begin
            r_pops_done <= r_pops_done + 10'd1;
          end
          if (wr_burst_finish) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            if (w_end_of_frame) begin
              r_offset     <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_offset <= r_offset + ADDR_BITS'(r_len);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_WR_STATS_EN
  logic [15:0] r_burst_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_burst_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_avail && (r_burst_cnt != 16'hFFFF)) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
      if (in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign burst_cnt = r_burst_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign burst_cnt = '0;
  assign stall_cnt = '0;
`endif

  assign in_ready      = w_in_ready;
  assign wr_burst_req  = r_req;
  assign wr_burst_len  = r_len;
  assign wr_burst_addr = r_addr;
  assign wr_burst_data = r_rd_data;
  assign frame_done    = r_frame_done;
  assign fifo_level    = r_level;

endmodule

// File: tb/tb_mem_wr_burst_feeder.sv
// Directed bench for mem_wr_burst_feeder with a small FIFO and BURST_LEN=4.
// Stats expectations follow MEM_WR_STATS_EN when it is defined for the build.
module tb_mem_wr_burst_feeder;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int FAW = 4;
  localparam int BL  = 4;

  logic           mem_clk;
  logic           rst;
  logic [AW-1:0]  base_addr;
  logic [AW-1:0]  frame_words;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           wr_burst_req;
  logic [9:0]     wr_burst_len;
  logic [AW-1:0]  wr_burst_addr;
  logic           wr_burst_data_req;
  logic [DW-1:0]  wr_burst_data;
  logic           wr_burst_finish;
  logic           frame_done;
  logic [FAW:0]   fifo_level;
  logic [15:0]    burst_cnt;
  logic [15:0]    stall_cnt;

  int checks   = 0;
  int failures = 0;

  mem_wr_burst_feeder #(
    .MEM_DATA_BITS(DW),
    .ADDR_BITS    (AW),
    .FIFO_AW      (FAW),
    .BURST_LEN    (BL)
  ) dut (
    .mem_clk          (mem_clk),
    .rst              (rst),
    .base_addr        (base_addr),
    .frame_words      (frame_words),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data    (wr_burst_data),
    .wr_burst_finish  (wr_burst_finish),
    .frame_done       (frame_done),
    .fifo_level       (fifo_level),
    .burst_cnt        (burst_cnt),
    .stall_cnt        (stall_cnt)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge mem_clk);
    rst = 1'b1;
    in_valid = 1'b0;
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    flush = 1'b0;
    @(negedge mem_clk);
    @(negedge mem_clk);
    rst = 1'b0;
    @(negedge mem_clk);
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge mem_clk);
      in_valid = 1'b1;
      in_data  = first + DW'(i);
    end
    @(negedge mem_clk);
    in_valid = 1'b0;
  endtask

  // Controller model: waits for req, strobes data_req len+1 times, then finish.
  task automatic do_burst(input logic [AW-1:0] exp_addr, input int exp_len,
                          input logic [DW-1:0] first, input logic exp_fd,
                          input logic push_first, input logic [DW-1:0] push_val,
                          input int exp_lvl);
    int waited;
    waited = 0;
    while (wr_burst_req !== 1'b1 && waited < 100) begin
      @(negedge mem_clk);
      waited++;
    end
    checks++;
    if (wr_burst_req !== 1'b1) begin
      failures++;
      $display("FAIL burst_req_timeout got=%b want=1 addr=%h", wr_burst_req, exp_addr);
      return;
    end
    checks++;
    if (wr_burst_addr !== exp_addr) begin
      failures++;
      $display("FAIL burst_addr got=%h want=%h", wr_burst_addr, exp_addr);
    end
    checks++;
    if (wr_burst_len !== 10'(exp_len)) begin
      failures++;
      $display("FAIL burst_len got=%0d want=%0d", wr_burst_len, exp_len);
    end
    for (int i = 0; i <= exp_len; i++) begin
      wr_burst_data_req = 1'b1;
      if (push_first && i == 0) begin
        in_valid = 1'b1;
        in_data  = push_val;
      end
      @(negedge mem_clk);
      in_valid = 1'b0;
      if (i < exp_len) begin
        checks++;
        if (wr_burst_data !== first + DW'(i)) begin
          failures++;
          $display("FAIL burst_data[%0d] got=%h want=%h", i, wr_burst_data, first + DW'(i));
        end
      end
      if (push_first && i == 0) begin
        checks++;
        if (fifo_level !== (FAW + 1)'(exp_lvl)) begin
          failures++;
          $display("FAIL push_pop_level got=%0d want=%0d", fifo_level, exp_lvl);
        end
      end
    end
    wr_burst_data_req = 1'b0;
    checks++;
    if (wr_burst_data !== first + DW'(exp_len - 1)) begin
      failures++;
      $display("FAIL extra_data_req_hold got=%h want=%h", wr_burst_data, first + DW'(exp_len - 1));
    end
    wr_burst_finish = 1'b1;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    checks++;
    if (wr_burst_req !== 1'b0) begin
      failures++;
      $display("FAIL req_after_finish got=%b want=0", wr_burst_req);
    end
    checks++;
    if (frame_done !== exp_fd) begin
      failures++;
      $display("FAIL frame_done got=%b want=%b", frame_done, exp_fd);
    end
    @(negedge mem_clk);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_pulse got=%b want=0", frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge mem_clk);
    @(negedge mem_clk);
    checks++;
    if ({wr_burst_req, frame_done, in_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000", {wr_burst_req, frame_done, in_ready});
    end
    checks++;
    if (fifo_level !== '0 || wr_burst_len !== '0 || wr_burst_addr !== '0 || wr_burst_data !== '0) begin
      failures++;
      $display("FAIL reset_regs level=%0d len=%0d addr=%h data=%h want all 0",
               fifo_level, wr_burst_len, wr_burst_addr, wr_burst_data);
    end
    rst = 1'b0;
    @(negedge mem_clk);
    checks++;
    if (in_ready !== 1'b1 || wr_burst_req !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got ready=%b req=%b want ready=1 req=0", in_ready, wr_burst_req);
    end
  endtask

  task automatic test_two_bursts();
    base_addr   = 16'h0100;
    frame_words = 16'd8;
    push_words(8, 16'hD000);
    do_burst(16'h0100, 4, 16'hD000, 1'b0, 1'b0, '0, 0);
    do_burst(16'h0104, 4, 16'hD004, 1'b1, 1'b0, '0, 0);
    checks++;
    if (fifo_level !== '0) begin
      failures++;
      $display("FAIL two_bursts_level got=%0d want=0", fifo_level);
    end
`ifdef MEM_WR_STATS_EN
    checks++;
    if (burst_cnt !== 16'd2) begin
      failures++;
      $display("FAIL stats_burst_cnt got=%0d want=2", burst_cnt);
    end
`endif
  endtask

  task automatic test_short_tail();
    base_addr   = 16'h0200;
    frame_words = 16'd6;
    push_words(6, 16'hA000);
    do_burst(16'h0200, 4, 16'hA000, 1'b0, 1'b0, '0, 0);
    do_burst(16'h0204, 2, 16'hA004, 1'b1, 1'b0, '0, 0);
  endtask

  task automatic test_flush();
    logic seen_req;
    base_addr   = 16'h0300;
    frame_words = 16'd8;
    push_words(3, 16'hB000);
    seen_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge mem_clk);
      if (wr_burst_req === 1'b1) seen_req = 1'b1;
    end
    checks++;
    if (seen_req !== 1'b0) begin
      failures++;
      $display("FAIL no_flush_req got=%b want=0", seen_req);
    end
    checks++;
    if (fifo_level !== 5'd3) begin
      failures++;
      $display("FAIL flush_level got=%0d want=3", fifo_level);
    end
    flush = 1'b1;
    do_burst(16'h0300, 3, 16'hB000, 1'b0, 1'b0, '0, 0);
    flush = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    base_addr   = 16'h0000;
    frame_words = 16'd100;
    @(negedge mem_clk);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    for (int i = 0; i < 25; i++) @(negedge mem_clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if (fifo_level !== 5'd16) begin
      failures++;
      $display("FAIL full_level got=%0d want=16", fifo_level);
    end
    in_valid = 1'b0;
`ifdef MEM_WR_STATS_EN
    checks++;
    if (stall_cnt !== 16'd9) begin
      failures++;
      $display("FAIL stats_stall_cnt got=%0d want=9", stall_cnt);
    end
    checks++;
    if (burst_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stats_burst_cnt_fill got=%0d want=1", burst_cnt);
    end
`else
    checks++;
    if (stall_cnt !== 16'd0 || burst_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stats_tied got stall=%0d burst=%0d want 0 0", stall_cnt, burst_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    checks++;
    if (wr_burst_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_burst_pre_req got=%b want=1", wr_burst_req);
    end
    rst = 1'b1;
    @(negedge mem_clk);
    checks++;
    if (wr_burst_req !== 1'b0 || fifo_level !== '0) begin
      failures++;
      $display("FAIL mid_burst_reset got req=%b level=%0d want req=0 level=0", wr_burst_req, fifo_level);
    end
    rst = 1'b0;
    base_addr   = 16'h0400;
    frame_words = 16'd8;
    push_words(4, 16'hC000);
    do_burst(16'h0400, 4, 16'hC000, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_push_pop_same_cycle();
    do_reset();
    base_addr   = 16'h0500;
    frame_words = 16'd8;
    push_words(5, 16'hE000);
    checks++;
    if (fifo_level !== 5'd5) begin
      failures++;
      $display("FAIL pre_push_pop_level got=%0d want=5", fifo_level);
    end
    do_burst(16'h0500, 4, 16'hE000, 1'b0, 1'b1, 16'hE005, 5);
    push_words(2, 16'hE006);
    do_burst(16'h0504, 4, 16'hE004, 1'b1, 1'b0, '0, 0);
  endtask

  initial begin
    rst               = 1'b1;
    base_addr         = '0;
    frame_words       = 16'd8;
    flush             = 1'b0;
    in_valid          = 1'b0;
    in_data           = '0;
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    test_reset();
    test_two_bursts();
    test_short_tail();
    test_flush();
    test_fill();
    test_reset_mid_burst();
    test_push_pop_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
